acq_sequencer: RTL

Acquisition sequencer between the SPI command receiver and the photon counter datapath. It decodes 16-bit command words into start, stop, set-period and clear-overrun actions. It runs repeated gated integration windows of programmable length by driving the counter's clear and enable lines. At the end of each window it latches the count for SPI readout and holds it behind a valid/ack handshake, with overrun detection.

---
 rtl/acq_pkg.sv | 31 +++
 rtl/acq_cmd_decode.sv | 33 +++
 rtl/acq_sequencer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/acq_pkg.sv
// ---- acq_pkg : shared types, command constants and nibble helper for acq_sequencer ----
// ---- rev 1.0 ----
`default_nettype none

package acq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CLEAR     = 2'd1,
    ST_INTEGRATE = 2'd2,
    ST_LATCH     = 2'd3
  } state_t;

  localparam logic [3:0]  CMD_SET_NIB   = 4'hC;
  localparam logic [15:0] CMD_CLR_OVR   = 16'h5A5A;
  localparam logic [3:0]  CMD_START_NIB = 4'hF;
  localparam logic [3:0]  CMD_STOP_NIB  = 4'h0;

  // Number of nibbles in word equal to nibble (0..4); gives single-nibble error tolerance
  function automatic logic [2:0] nib_match(input logic [15:0] word, input logic [3:0] nibble);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (word[4*i +: 4] == nibble) n = n + 3'd1;
    end
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/acq_cmd_decode.sv
// ---- acq_cmd_decode : combinational SPI command word decoder (START > STOP > CLR_OVR > SET) ----
// ---- rev 1.0 ----
`default_nettype none

module acq_cmd_decode
  import acq_pkg::*;
(
  input  logic        cmd_valid,
  input  logic [15:0] command,
  output logic        is_start,
  output logic        is_stop,
  output logic        is_clr,
  output logic        is_set,
  output logic [11:0] period_val
);

  always_comb begin
    is_start   = 1'b0;
    is_stop    = 1'b0;
    is_clr     = 1'b0;
    is_set     = 1'b0;
    period_val = command[11:0];
    if (cmd_valid) begin
      if (nib_match(command, CMD_START_NIB) >= 3'd3)      is_start = 1'b1;
      else if (nib_match(command, CMD_STOP_NIB) >= 3'd3)  is_stop  = 1'b1;
      else if (command == CMD_CLR_OVR)                    is_clr   = 1'b1;
      else if (command[15:12] == CMD_SET_NIB)             is_set   = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/acq_sequencer.sv
// ---- acq_sequencer : gated integration window sequencer with latched result and valid/ack ----
// ---- rev 1.0 ----
`default_nettype none

module acq_sequencer
  import acq_pkg::*;
#(
  parameter int          COUNT_W    = 32,
  parameter int          TICK_DIV   = 1000,
  parameter logic [11:0] PERIOD_RST = 12'd100
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  input  logic [15:0]        command,
  input  logic [COUNT_W-1:0] cnt_value,
  output logic               cnt_clear,
  output logic               cnt_enable,
  output logic [COUNT_W-1:0] result,
  output logic               result_valid,
  input  logic               result_ack,
  output logic [15:0]        frame_idx,
  output logic               busy,
  output logic               overrun
);

  localparam int                 PRESC_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);

  logic        is_start;
  logic        is_stop;
  logic        is_clr;
  logic        is_set;
  logic [11:0] period_val;

  state_t             state;
  logic [11:0]        period;
  logic [11:0]        act_period;
  logic [PRESC_W-1:0] presc;
  logic [11:0]        tick;
  logic [15:0]        frame_cnt;

  acq_cmd_decode u_decode (
    .cmd_valid  (cmd_valid),
    .command    (command),
    .is_start   (is_start),
    .is_stop    (is_stop),
    .is_clr     (is_clr),
    .is_set     (is_set),
    .period_val (period_val)
  );

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      period       <= PERIOD_RST;
      act_period   <= PERIOD_RST;
      presc        <= '0;
      tick         <= '0;
      frame_cnt    <= '0;
      cnt_clear    <= 1'b0;
      cnt_enable   <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      frame_idx    <= '0;
      overrun      <= 1'b0;
    end else begin
      cnt_clear <= 1'b0;
      if (is_set && (period_val != 12'd0)) period <= period_val;
      if (is_clr)     overrun      <= 1'b0;
      if (result_ack) result_valid <= 1'b0;

      if (is_stop && (state != ST_IDLE)) begin
        state      <= ST_IDLE;
        cnt_enable <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (is_start) begin
              state     <= ST_CLEAR;
              cnt_clear <= 1'b1;
              frame_cnt <= '0;
            end
          end
          ST_CLEAR: begin
            // Period is frozen for the whole window so SET_PERIOD only affects later frames
            state      <= ST_INTEGRATE;
            cnt_enable <= 1'b1;
            act_period <= period;
            presc      <= '0;
            tick       <= '0;
          end
          ST_INTEGRATE: begin
            if (presc == PRESC_MAX) begin
              presc <= '0;
              if (tick == act_period - 12'd1) begin
                state      <= ST_LATCH;
                cnt_enable <= 1'b0;
              end else begin
                tick <= tick + 12'd1;
              end
            end else begin
              presc <= presc + PRESC_W'(1);
            end
          end
          ST_LATCH: begin
            state        <= ST_CLEAR;
            cnt_clear    <= 1'b1;
            result       <= cnt_value;
            result_valid <= 1'b1;
            frame_idx    <= frame_cnt;
            frame_cnt    <= frame_cnt + 16'd1;
            // An ack arriving with the capture reads the old frame, so it is not lost
            if (result_valid && !result_ack) overrun <= 1'b1;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire
